// File: rtl/row_chain_serializer_pkg.sv
// Shared constants and state encodings for the per-row chain capture and serial output path.
package row_chain_serializer_pkg;

  localparam int unsigned BitsAdc     = 12;
  localparam int unsigned Dw          = BitsAdc + 1;
  localparam int unsigned Blocks      = 8;
  localparam int unsigned Ch          = 4;
  localparam int unsigned ChainLat    = 2;
  localparam int unsigned Depth       = 32;
  localparam int unsigned LenW        = 6;
  localparam logic [Dw-1:0] Terminator = {Dw{1'b1}};

  typedef enum logic [1:0] {
    CapIdle,
    CapWait,
    CapCapture,
    CapDone
  } cap_state_e;

  typedef enum logic {
    SerIdle,
    SerShift
  } ser_state_e;

endpackage

// File: rtl/row_chain_serializer_row_word_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop frees a slot this cycle.
module row_word_fifo #(
  parameter int unsigned Width = 14,
  parameter int unsigned Depth = 32
) (
  input  logic             clk_3p2M,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_wdata,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [Width-1:0] r_mem [Depth];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_3p2M or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_3p2M) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/row_chain_serializer.sv
// Captures one row's daisy-chain frame on each samp rising edge and streams the words
// MSB-first on a serial line with a valid strobe and a frame-start tag.
module row_chain_serializer
  import row_chain_serializer_pkg::*;
#(
  parameter int unsigned DW        = Dw,
  parameter int unsigned BLOCKS    = Blocks,
  parameter int unsigned CH        = Ch,
  parameter int unsigned CHAIN_LAT = ChainLat,
  parameter int unsigned DEPTH     = Depth
) (
  input  logic            clk_3p2M,
  input  logic            rst_n,
  input  logic            i_samp,
  input  logic            i_en,
  input  logic [DW-1:0]   i_chain_in,
  output logic            o_s_data,
  output logic            o_data_valid,
  output logic            o_frame_start,
  output logic [LenW-1:0] o_frame_len,
  output logic            o_overflow,
  output logic            o_sync_err
);

  localparam int unsigned FrameW = BLOCKS * CH;
  localparam int unsigned BitW   = $clog2(DW);
  localparam int unsigned WaitW  = $clog2(CHAIN_LAT) + 1;

  cap_state_e      r_cap_state, w_cap_next;
  ser_state_e      r_ser_state, w_ser_next;
  logic            r_samp_d;
  logic [WaitW-1:0] r_wait_cnt;
  logic [LenW-1:0] r_wcnt;
  logic [LenW-1:0] r_frame_len;
  logic            r_overflow;
  logic            r_sync_err;
  logic [DW-1:0]   r_shreg;
  logic            r_tag;
  logic [BitW-1:0] r_bitcnt;

  logic            w_edge;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [DW:0]     w_rdata;

  assign w_edge = i_samp & ~r_samp_d;

  always_comb begin
    w_cap_next = r_cap_state;
    w_push     = 1'b0;
    unique case (r_cap_state)
      CapIdle:    if (w_edge && i_en) w_cap_next = CapWait;
      CapWait:    if (r_wait_cnt == WaitW'(CHAIN_LAT - 1)) w_cap_next = CapCapture;
      CapCapture: begin
        // An all-ones word marks the end of a short chain and is never stored.
        if (&i_chain_in) begin
          w_cap_next = CapDone;
        end else begin
          w_push = 1'b1;
          if (r_wcnt == LenW'(FrameW - 1)) w_cap_next = CapDone;
        end
      end
      CapDone:    w_cap_next = CapIdle;
      default:    w_cap_next = CapIdle;
    endcase
  end

  always_ff @(posedge clk_3p2M or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_state <= CapIdle;
      r_samp_d    <= 1'b0;
      r_wait_cnt  <= '0;
      r_wcnt      <= '0;
      r_frame_len <= '0;
      r_overflow  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_cap_state <= w_cap_next;
      r_samp_d    <= i_samp;
      r_wait_cnt  <= (r_cap_state == CapWait) ? r_wait_cnt + WaitW'(1) : '0;
      if (r_cap_state == CapIdle) r_wcnt <= '0;
      else if (w_push)            r_wcnt <= r_wcnt + LenW'(1);
      if (r_cap_state == CapDone) r_frame_len <= r_wcnt;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_edge && (r_cap_state != CapIdle)) r_sync_err <= 1'b1;
    end
  end

  row_word_fifo #(
    .Width (DW + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_3p2M (clk_3p2M),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wdata  ({(r_wcnt == '0), i_chain_in}),
    .o_rdata  (w_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_comb begin
    w_ser_next = r_ser_state;
    w_pop      = 1'b0;
    unique case (r_ser_state)
      SerIdle: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_ser_next = SerShift;
        end
      end
      SerShift: begin
        // Reload on the last bit so consecutive words stream without a gap.
        if (r_bitcnt == BitW'(DW - 1)) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_ser_next = SerIdle;
        end
      end
      default: w_ser_next = SerIdle;
    endcase
  end

  always_ff @(posedge clk_3p2M or negedge rst_n) begin
    if (!rst_n) begin
      r_ser_state <= SerIdle;
      r_shreg     <= '0;
      r_tag       <= 1'b0;
      r_bitcnt    <= '0;
    end else begin
      r_ser_state <= w_ser_next;
      if (w_pop) begin
        r_shreg  <= w_rdata[DW-1:0];
        r_tag    <= w_rdata[DW];
        r_bitcnt <= '0;
      end else if (r_ser_state == SerShift) begin
        r_shreg  <= {r_shreg[DW-2:0], 1'b0};
        r_bitcnt <= r_bitcnt + BitW'(1);
      end
    end
  end

  assign o_data_valid  = (r_ser_state == SerShift);
  assign o_s_data      = o_data_valid & r_shreg[DW-1];
  assign o_frame_start = o_data_valid & r_tag & (r_bitcnt == '0);
  assign o_frame_len   = r_frame_len;
  assign o_overflow    = r_overflow;
  assign o_sync_err    = r_sync_err;

endmodule
